// File: rtl/hs_link_pipe.sv
// hs_link_pipe: arithmetic-sequence master -> 2-entry skid slice -> checking slave.
module hs_link_pipe #(
  parameter int DATA_W    = 3,
  parameter int STEP      = 1,
  parameter int START_VAL = 0,
  parameter int CNT_W     = 16
) (
  input  logic              sys_clk,
  input  logic              rst_n,
  input  logic              valid_in,
  input  logic              ready_in,
  output logic [DATA_W-1:0] result,
  output logic [CNT_W-1:0]  xfer_cnt,
  output logic              err,
  output logic [1:0]        occupancy
);
  localparam logic [DATA_W-1:0] STEP_V  = DATA_W'(STEP);
  localparam logic [DATA_W-1:0] START_V = DATA_W'(START_VAL);
  logic              m_valid, m_ready, s_valid, push, pop, wr_ptr, rd_ptr;
  logic [DATA_W-1:0] m_data, next_val, expected, s_data;
  logic [DATA_W-1:0] mem [2];
  // m_ready decodes only the occupancy register, so ready_in never reaches the master
  assign m_ready = occupancy != 2'd2;
  assign s_valid = occupancy != 2'd0;
  assign s_data  = mem[rd_ptr];
  assign push    = m_valid && m_ready;
  assign pop     = s_valid && ready_in;
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      m_valid  <= 1'b0;
      m_data   <= START_V;
      next_val <= START_V;
    end else if (!m_valid || m_ready) begin
      m_valid <= valid_in;
      if (valid_in) begin
        m_data   <= next_val;
        next_val <= next_val + STEP_V;
      end
    end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      mem[0]    <= '0;
      mem[1]    <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= m_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      occupancy <= occupancy + 2'(push) - 2'(pop);
    end
  always_ff @(posedge sys_clk or negedge rst_n)
    if (!rst_n) begin
      result   <= '0;
      xfer_cnt <= '0;
      err      <= 1'b0;
      expected <= START_V;
    end else if (pop) begin
      result <= s_data;
      if (xfer_cnt != '1) xfer_cnt <= xfer_cnt + 1'b1;
      if (s_data != expected) err <= 1'b1;
      expected <= s_data + STEP_V;
    end
endmodule
